debug_dump_tx: RTL and testbench
================================

Name: debug_dump_tx

Overview:
Parametrised successor of the debug-unit transmit path. On a halt, or on a step in step mode, it captures a snapshot and streams one framed dump to the 8-bit UART transmitter: header byte, PC, every register, a configurable window of data memory (fetched through a read port), and the cycle counter. It sits between the datapath/debug inputs and the UART TX, and pulses o_done when the frame has fully left the UART.

Parameters:
NB_DATA, 32, datapath word width; must be a multiple of 8
N_REGS, 32, number of registers in i_registers
N_MEM_WORDS, 32, number of consecutive data-memory words dumped, starting at word address 0
NB_MEM_ADDR, 5, width of o_mem_addr; must satisfy 2^NB_MEM_ADDR >= N_MEM_WORDS
FRAME_HEADER, 8'hA5, first byte of every frame

Ports:
i_clock  in  1  clock
i_reset  in  1  reset; i_reset, synchronous, active-high; clock i_clock
i_pc  in  NB_DATA  program counter
i_registers  in  NB_DATA*N_REGS  flat register file; reg k is bits [k*NB_DATA +: NB_DATA]
i_cycles  in  NB_DATA  executed-cycle counter
i_mem_data  in  NB_DATA  read data; valid exactly one cycle after o_mem_rd_en
i_execution_mode  in  1  1 = step mode
i_step  in  1  step pulse
i_halt  in  1  program halted
i_tx_done  in  1  one-cycle pulse from the UART TX when a byte has been sent
o_tx_byte  out  8  byte to transmit; held stable from o_tx_start until i_tx_done
o_tx_start  out  1  one-cycle start pulse to the UART TX
o_mem_rd_en  out  1  memory read strobe
o_mem_addr  out  NB_MEM_ADDR  memory word address
o_busy  out  1  high from trigger acceptance until o_done
o_done  out  1  one-cycle pulse after the last byte's i_tx_done

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters 0. A reset mid-frame aborts the frame immediately. No o_done is produced, and the next frame restarts from the header.
- Trigger: in IDLE, (i_halt | (i_execution_mode & i_step)) is accepted on that clock edge.
  - i_pc and i_cycles are captured into snapshot registers on the acceptance edge.
  - Registers are sampled live when each word is loaded.
  - Triggers seen while o_busy=1 are ignored, not queued.
  - i_halt held high re-triggers one cycle after o_done, so software drives one dump per halt via the mode/step protocol.
- Frame order:
  - FRAME_HEADER.
  - Word index w = 0: PC.
  - w = 1..N_REGS: reg 0..N_REGS-1.
  - Next N_MEM_WORDS words: mem 0..N_MEM_WORDS-1.
  - Last word: cycles.
  - Each word is sent little-endian: NB_DATA/8 bytes, LSB first.
  - Total bytes = 1 + (N_REGS+N_MEM_WORDS+2)*NB_DATA/8.
- FSM states:
  - IDLE: on trigger -> HDR. Set o_busy=1 and capture the snapshot.
  - HDR: load FRAME_HEADER into the byte register, byte count = 1 -> SEND.
  - LOAD: select word w into the shift register, byte count = NB_DATA/8. If w is a memory word -> MEM_REQ; otherwise -> SEND.
  - MEM_REQ: o_mem_rd_en=1 for one cycle, o_mem_addr = w-1-N_REGS -> MEM_CAP.
  - MEM_CAP: shift register <= i_mem_data -> SEND.
  - SEND: o_tx_start=1 for exactly one cycle, o_tx_byte = shift[7:0] -> WAIT.
  - WAIT: on i_tx_done, shift >>= 8 and byte count decrements. Then:
    - bytes remain -> SEND;
    - else if the header was just sent -> LOAD (w=0);
    - else if w is the last index -> FIN;
    - else w++ -> LOAD.
    - i_tx_done in any state other than WAIT is ignored.
  - FIN: o_done=1 for one cycle, o_busy=0 -> IDLE.
- Latency:
  - Trigger to first o_tx_start: 2 cycles.
  - i_tx_done to next o_tx_start: 1 cycle within a word, 2 cycles for a register word, 4 cycles for a memory word.
  - Last i_tx_done to o_done: 1 cycle.
- Counters and outputs:
  - w counter width is clog2(N_REGS+N_MEM_WORDS+2); it never wraps within a frame.
  - The byte counter is clog2(NB_DATA/8)+1 bits.
  - o_mem_addr holds its last value when not reading.
  - o_tx_byte holds its value after WAIT.
- N_MEM_WORDS = 0 is legal: the memory states are skipped and cycles follows the last register.

Decomposition:
- Shared package debug_pkg: state encodings, FRAME_HEADER, the byte-count function, and frame-length constants used by the host-side decoder and the test bench.
- One natural sub-module, debug_word_serializer. It takes a word-load plus NB_DATA word, produces byte/start pulses, consumes tx_done, and emits word_done.
- The dump FSM sequences words through the serializer.

Test Plan:
Bench configuration: NB_DATA=32, N_REGS=4, N_MEM_WORDS=2; the UART model returns i_tx_done 5 cycles after each start.

1. i_halt=1, pc=0x00000010, regs 0x11111111..0x44444444, mem[0]=0xDEADBEEF, mem[1]=0x0BADF00D, cycles=0x00000007 -> exactly 33 bytes: A5, 10 00 00 00, 11 11 11 11, …, EF BE AD DE, 0D F0 AD 0B, 07 00 00 00; then o_done one cycle after the 33rd i_tx_done.
2. i_execution_mode=0 with i_step pulses -> no o_tx_start. Then i_execution_mode=1 with one i_step pulse -> one complete frame.
3. Re-trigger while busy: i_step pulses at bytes 3 and 20 -> exactly one frame. pc changes to 0x20 mid-frame -> the frame still carries 0x10.
4. Memory port: exactly 2 o_mem_rd_en pulses, addr 0 then 1. i_mem_data is driven only in the cycle after each strobe and set to X otherwise -> no X appears on o_tx_byte.
5. i_reset asserted during byte 12 -> all outputs 0 the next cycle, no o_done. A new trigger afterwards starts again with A5.
6. Spurious i_tx_done during IDLE and during LOAD -> ignored; frame contents and byte count stay unchanged.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the debug dump transmit path and its host-side decoder.
// Frame layout: header byte, then PC, registers, memory window and cycle counter, each LSB first.
package debug_pkg;

  localparam logic [7:0] FRAME_HEADER_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_MEM_REQ,
    ST_MEM_CAP,
    ST_SER,
    ST_FIN
  } dump_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SEND,
    SER_WAIT
  } ser_state_e;

  function automatic int bytes_per_word(input int nb_data);
    return nb_data / 8;
  endfunction

  function automatic int frame_words(input int n_regs, input int n_mem_words);
    return n_regs + n_mem_words + 2;
  endfunction

  function automatic int frame_bytes(input int nb_data, input int n_regs, input int n_mem_words);
    return 1 + frame_words(n_regs, n_mem_words) * bytes_per_word(nb_data);
  endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// Splits one loaded word into bytes, LSB first, and paces them against the UART:
// a start pulse per byte, then wait for tx_done before the next byte.
module debug_word_serializer
  import debug_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_CNT  = $clog2(NB_DATA / 8) + 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic [NB_CNT-1:0]  i_nbytes,
  input  logic               i_tx_done,
  output logic [7:0]         o_tx_byte,
  output logic               o_tx_start,
  output logic               o_word_done
);

  ser_state_e         state_q, state_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic [7:0]         byte_q, byte_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= SER_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
    end
  end

  // i_load is only honoured while idle; tx_done only while a byte is in flight.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    case (state_q)
      SER_IDLE: begin
        if (i_load) begin
          shift_d = i_word;
          cnt_d   = i_nbytes;
          state_d = SER_SEND;
        end
      end
      SER_SEND: begin
        byte_d  = shift_q[7:0];
        state_d = SER_WAIT;
      end
      SER_WAIT: begin
        if (i_tx_done) begin
          shift_d = shift_q >> 8;
          cnt_d   = cnt_q - NB_CNT'(1);
          state_d = (cnt_q == NB_CNT'(1)) ? SER_IDLE : SER_SEND;
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_comb begin
    o_tx_start  = (state_q == SER_SEND);
    o_tx_byte   = (state_q == SER_SEND) ? shift_q[7:0] : byte_q;
    o_word_done = (state_q == SER_WAIT) && i_tx_done && (cnt_q == NB_CNT'(1));
  end

endmodule

// File: rtl/debug_dump_tx.sv
// Debug dump transmitter: on halt or step-mode step, streams a framed snapshot
// (header, PC, registers, memory window, cycle count) to the byte UART.
module debug_dump_tx
  import debug_pkg::*;
#(
  parameter int         NB_DATA      = 32,
  parameter int         N_REGS       = 32,
  parameter int         N_MEM_WORDS  = 32,
  parameter int         NB_MEM_ADDR  = 5,
  parameter logic [7:0] FRAME_HEADER = FRAME_HEADER_DEFAULT
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NB_DATA-1:0]        i_pc,
  input  logic [NB_DATA*N_REGS-1:0] i_registers,
  input  logic [NB_DATA-1:0]        i_cycles,
  input  logic [NB_DATA-1:0]        i_mem_data,
  input  logic                      i_execution_mode,
  input  logic                      i_step,
  input  logic                      i_halt,
  input  logic                      i_tx_done,
  output logic [7:0]                o_tx_byte,
  output logic                      o_tx_start,
  output logic                      o_mem_rd_en,
  output logic [NB_MEM_ADDR-1:0]    o_mem_addr,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int N_WORDS = frame_words(N_REGS, N_MEM_WORDS);
  localparam int NB_W    = $clog2(N_WORDS);
  localparam int NB_CNT  = $clog2(bytes_per_word(NB_DATA)) + 1;
  localparam logic [NB_W-1:0] LAST_W = NB_W'(N_WORDS - 1);

  dump_state_e            state_q, state_d;
  logic [NB_W-1:0]        w_q, w_d;
  logic                   hdr_q, hdr_d;
  logic [NB_DATA-1:0]     pc_q, pc_d;
  logic [NB_DATA-1:0]     cyc_q, cyc_d;
  logic [NB_MEM_ADDR-1:0] addr_q, addr_d;

  logic                   trigger;
  int                     w_int;
  logic [NB_DATA-1:0]     word_sel;
  logic                   is_mem;
  logic [NB_MEM_ADDR-1:0] mem_addr_w;

  logic                   ser_load;
  logic [NB_DATA-1:0]     ser_word;
  logic [NB_CNT-1:0]      ser_nbytes;
  logic                   ser_word_done;

  assign trigger = i_halt | (i_execution_mode & i_step);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      hdr_q   <= 1'b0;
      pc_q    <= '0;
      cyc_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      hdr_q   <= hdr_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
    end
  end

  // Word index w: 0 = PC, 1..N_REGS = registers (sampled live), then memory, last = cycles.
  always_comb begin
    w_int    = int'(w_q);
    word_sel = cyc_q;
    if (w_int == 0) word_sel = pc_q;
    for (int k = 0; k < N_REGS; k++) begin
      if (w_int == k + 1) word_sel = i_registers[k*NB_DATA +: NB_DATA];
    end
    is_mem     = (w_int > N_REGS) && (w_int <= N_REGS + N_MEM_WORDS);
    mem_addr_w = NB_MEM_ADDR'(w_int - N_REGS - 1);
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    hdr_d   = hdr_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          pc_d    = i_pc;
          cyc_d   = i_cycles;
          w_d     = '0;
          hdr_d   = 1'b0;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        hdr_d   = 1'b1;
        state_d = ST_SER;
      end
      ST_LOAD: begin
        if (is_mem) begin
          addr_d  = mem_addr_w;
          state_d = ST_MEM_REQ;
        end else begin
          state_d = ST_SER;
        end
      end
      ST_MEM_REQ: state_d = ST_MEM_CAP;
      ST_MEM_CAP: state_d = ST_SER;
      ST_SER: begin
        if (ser_word_done) begin
          if (hdr_q) begin
            hdr_d   = 1'b0;
            w_d     = '0;
            state_d = ST_LOAD;
          end else if (w_q == LAST_W) begin
            state_d = ST_FIN;
          end else begin
            w_d     = w_q + NB_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // UART handshake: o_tx_start is a one-cycle request; o_tx_byte stays put until the
  // matching i_tx_done pulse, and no new start is issued before that pulse arrives.
  always_comb begin
    ser_load    = 1'b0;
    ser_word    = word_sel;
    ser_nbytes  = NB_CNT'(bytes_per_word(NB_DATA));
    o_mem_rd_en = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (state_q)
      ST_IDLE: o_busy = 1'b0;
      ST_HDR: begin
        ser_load   = 1'b1;
        ser_word   = NB_DATA'(FRAME_HEADER);
        ser_nbytes = NB_CNT'(1);
      end
      ST_LOAD:    ser_load = !is_mem;
      ST_MEM_REQ: o_mem_rd_en = 1'b1;
      ST_MEM_CAP: begin
        ser_load = 1'b1;
        ser_word = i_mem_data;
      end
      ST_FIN: begin
        o_busy = 1'b0;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_mem_addr = addr_q;

  debug_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_CNT  (NB_CNT)
  ) u_serializer (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load      (ser_load),
    .i_word      (ser_word),
    .i_nbytes    (ser_nbytes),
    .i_tx_done   (i_tx_done),
    .o_tx_byte   (o_tx_byte),
    .o_tx_start  (o_tx_start),
    .o_word_done (ser_word_done)
  );

endmodule

// File: tb/tb_debug_dump_tx.sv
// Bench for debug_dump_tx: NB_DATA=32, N_REGS=4, N_MEM_WORDS=2, UART answering
// each start with tx_done five cycles later; expected bytes flow through a scoreboard.
module tb_debug_dump_tx;

  localparam int NB_DATA     = 32;
  localparam int N_REGS      = 4;
  localparam int N_MEM_WORDS = 2;
  localparam int NB_MEM_ADDR = 5;
  localparam int FRAME_LEN   = 33;

  // ---------------- clock / reset / DUT ----------------
  logic                      i_clock = 1'b0;
  logic                      i_reset = 1'b1;
  logic [NB_DATA-1:0]        i_pc = '0;
  logic [NB_DATA*N_REGS-1:0] i_registers = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  logic [NB_DATA-1:0]        i_cycles = '0;
  logic [NB_DATA-1:0]        i_mem_data = 'x;
  logic                      i_execution_mode = 1'b0;
  logic                      i_step = 1'b0;
  logic                      i_halt = 1'b0;
  logic                      i_tx_done = 1'b0;
  logic [7:0]                o_tx_byte;
  logic                      o_tx_start;
  logic                      o_mem_rd_en;
  logic [NB_MEM_ADDR-1:0]    o_mem_addr;
  logic                      o_busy;
  logic                      o_done;

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc = cyc + 1;

  debug_dump_tx #(
    .NB_DATA      (NB_DATA),
    .N_REGS       (N_REGS),
    .N_MEM_WORDS  (N_MEM_WORDS),
    .NB_MEM_ADDR  (NB_MEM_ADDR),
    .FRAME_HEADER (8'hA5)
  ) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_pc             (i_pc),
    .i_registers      (i_registers),
    .i_cycles         (i_cycles),
    .i_mem_data       (i_mem_data),
    .i_execution_mode (i_execution_mode),
    .i_step           (i_step),
    .i_halt           (i_halt),
    .i_tx_done        (i_tx_done),
    .o_tx_byte        (o_tx_byte),
    .o_tx_start       (o_tx_start),
    .o_mem_rd_en      (o_mem_rd_en),
    .o_mem_addr       (o_mem_addr),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0]             exp_q[$];
  int                     gap_q[$];
  logic [NB_MEM_ADDR-1:0] addr_q[$];
  logic [7:0]             frame_buf [FRAME_LEN];
  logic [7:0]             frame1 [FRAME_LEN];
  logic [31:0]            mem_img [2] = '{32'hDEADBEEF, 32'h0BADF00D};

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int ref_cyc = 0;
  int uart_cnt = 0;
  int real_done_cnt = 0;
  int spur_at_a = -1;
  int spur_at_b = -1;
  int spur_req_cnt = 0;
  int spur_ack_cnt = 0;
  int mem_req_cnt = 0;
  int mem_ack_cnt = 0;
  logic [NB_MEM_ADDR-1:0] mem_req_addr = '0;
  logic spur_pend = 1'b0;
  logic busy_prev = 1'b0;
  logic [7:0] cur_byte = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor + UART model (one process, sampled mid-cycle) ----------------
  always @(negedge i_clock) begin
    logic [7:0] e;
    int g;
    logic real_done;
    logic spur_done;
    real_done = 1'b0;
    spur_done = 1'b0;
    if (i_reset) begin
      exp_q.delete();
      gap_q.delete();
      addr_q.delete();
      uart_cnt  = 0;
      spur_pend = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (o_tx_start) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start: actual byte=%0h required=no start (cycle %0d)", o_tx_byte, cyc);
        end else begin
          e = exp_q.pop_front();
          g = gap_q.pop_front();
          check($sformatf("tx_byte_%0d", start_cnt), o_tx_byte, e);
          check($sformatf("start_gap_%0d", start_cnt), cyc - ref_cyc, g);
        end
        cur_byte = o_tx_byte;
      end
      if (o_mem_rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem_read: actual addr=%0h required=no read", o_mem_addr);
        end else begin
          check("mem_addr", o_mem_addr, addr_q.pop_front());
        end
        mem_req_addr = o_mem_addr;
        mem_req_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        check("done_latency", cyc - ref_cyc, 1);
        check("done_with_bytes_left", exp_q.size(), 0);
      end
      if (o_busy && !busy_prev) ref_cyc = cyc;
      busy_prev = o_busy;

      if (spur_pend) begin
        spur_done = 1'b1;
        spur_pend = 1'b0;
      end
      if (spur_req_cnt != spur_ack_cnt) begin
        spur_done    = 1'b1;
        spur_ack_cnt = spur_req_cnt;
      end
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) begin
          real_done = 1'b1;
          real_done_cnt++;
          ref_cyc = cyc;
          check("byte_stable_until_done", o_tx_byte, cur_byte);
          if (real_done_cnt == spur_at_a || real_done_cnt == spur_at_b) spur_pend = 1'b1;
        end
      end
      if (o_tx_start) uart_cnt = 5;
    end
    i_tx_done = real_done | spur_done;
  end

  // Memory model: data valid only in the cycle after the strobe, X otherwise.
  always begin
    @(posedge i_clock);
    #1;
    if (mem_ack_cnt != mem_req_cnt) begin
      mem_ack_cnt = mem_req_cnt;
      i_mem_data  = (mem_req_addr < 2) ? mem_img[mem_req_addr[0]] : 'x;
    end else begin
      i_mem_data = 'x;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic pulse_step();
    @(posedge i_clock); #1; i_step = 1'b1;
    @(posedge i_clock); #1; i_step = 1'b0;
  endtask

  task automatic pulse_halt();
    @(posedge i_clock); #1; i_halt = 1'b1;
    @(posedge i_clock); #1; i_halt = 1'b0;
  endtask

  task automatic build_frame(input logic [31:0] pc, input logic [31:0] cy);
    logic [31:0] words [8];
    words[0] = pc;
    words[1] = 32'h11111111;
    words[2] = 32'h22222222;
    words[3] = 32'h33333333;
    words[4] = 32'h44444444;
    words[5] = 32'hDEADBEEF;
    words[6] = 32'h0BADF00D;
    words[7] = cy;
    frame_buf[0] = 8'hA5;
    for (int wi = 0; wi < 8; wi++)
      for (int b = 0; b < 4; b++)
        frame_buf[1 + wi*4 + b] = words[wi][8*b +: 8];
  endtask

  // Gaps: header 1 cycle after busy rises; within a word 1; register/PC/cycles word 2; memory word 4.
  task automatic push_buf();
    for (int i = 0; i < FRAME_LEN; i++) begin
      exp_q.push_back(frame_buf[i]);
      if (i == 0 || (i - 1) % 4 != 0) gap_q.push_back(1);
      else if ((i - 1) / 4 == 5 || (i - 1) / 4 == 6) gap_q.push_back(4);
      else gap_q.push_back(2);
    end
    addr_q.push_back(5'd0);
    addr_q.push_back(5'd1);
  endtask

  task automatic wait_starts(input int target);
    int n;
    n = 0;
    while (start_cnt < target && n < 1000) begin
      @(negedge i_clock);
      n++;
    end
    check("wait_starts_in_time", start_cnt >= target, 1);
  endtask

  task automatic wait_frame(input string name, input int s0, input int r0, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(negedge i_clock);
      n++;
    end
    check({name, "_done_in_time"}, n < 2000, 1);
    check({name, "_byte_count"}, start_cnt - s0, FRAME_LEN);
    check({name, "_mem_reads"}, rd_cnt - r0, 2);
    check({name, "_queue_drained"}, exp_q.size(), 0);
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    tick(3);
  endtask

  task automatic check_outputs_zero(input string name);
    @(negedge i_clock);
    check(name, {o_tx_byte, o_tx_start, o_mem_rd_en, o_mem_addr, o_busy, o_done}, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0, r0, d0;
    frame1 = '{8'hA5,
               8'h10, 8'h00, 8'h00, 8'h00,
               8'h11, 8'h11, 8'h11, 8'h11,
               8'h22, 8'h22, 8'h22, 8'h22,
               8'h33, 8'h33, 8'h33, 8'h33,
               8'h44, 8'h44, 8'h44, 8'h44,
               8'hEF, 8'hBE, 8'hAD, 8'hDE,
               8'h0D, 8'hF0, 8'hAD, 8'h0B,
               8'h07, 8'h00, 8'h00, 8'h00};

    // Reset state
    tick(3);
    check_outputs_zero("reset_outputs");
    @(posedge i_clock); #1; i_reset = 1'b0;
    tick(2);

    // 1: halt-triggered frame with hand-computed bytes
    i_pc = 32'h10;
    i_cycles = 32'h7;
    s0 = start_cnt; r0 = rd_cnt; d0 = done_cnt;
    frame_buf = frame1;
    push_buf();
    pulse_halt();
    wait_frame("t1", s0, r0, d0);

    // 2: steps ignored outside step mode, then one stepped frame
    s0 = start_cnt;
    repeat (3) begin
      pulse_step();
      tick(2);
    end
    tick(30);
    check("t2_no_start_in_run_mode", start_cnt - s0, 0);
    check("t2_idle_not_busy", o_busy, 0);
    i_execution_mode = 1'b1;
    s0 = start_cnt; r0 = rd_cnt; d0 = done_cnt;
    build_frame(32'h10, 32'h7);
    push_buf();
    pulse_step();
    wait_frame("t2", s0, r0, d0);

    // 3: re-trigger while busy is dropped; snapshot survives input changes
    s0 = start_cnt; r0 = rd_cnt; d0 = done_cnt;
    build_frame(32'h10, 32'h7);
    push_buf();
    pulse_step();
    wait_starts(s0 + 3);
    pulse_step();
    wait_starts(s0 + 20);
    i_pc = 32'h20;
    i_cycles = 32'h99;
    pulse_step();
    wait_frame("t3", s0, r0, d0);
    tick(40);
    check("t3_no_extra_frame", start_cnt - s0, FRAME_LEN);

    // 5: reset during byte 12 aborts without done; next frame restarts at the header
    i_execution_mode = 1'b0;
    i_pc = 32'h10;
    i_cycles = 32'h7;
    s0 = start_cnt; d0 = done_cnt;
    build_frame(32'h10, 32'h7);
    push_buf();
    pulse_halt();
    wait_starts(s0 + 12);
    @(posedge i_clock); #1; i_reset = 1'b1;
    @(posedge i_clock); #1; i_reset = 1'b0;
    check_outputs_zero("t5_reset_abort_outputs");
    tick(60);
    check("t5_no_done_after_abort", done_cnt - d0, 0);
    check("t5_no_bytes_after_abort", start_cnt - s0, 12);
    check("t5_idle_after_abort", o_busy, 0);
    i_pc = 32'h30;
    i_cycles = 32'h9;
    s0 = start_cnt; r0 = rd_cnt; d0 = done_cnt;
    build_frame(32'h30, 32'h9);
    push_buf();
    pulse_halt();
    wait_frame("t5_restart", s0, r0, d0);

    // 6: spurious tx_done in IDLE and in LOAD is ignored
    s0 = start_cnt;
    repeat (3) begin
      spur_req_cnt++;
      tick(3);
    end
    tick(10);
    check("t6_idle_spurious_no_start", start_cnt - s0, 0);
    check("t6_idle_spurious_not_busy", o_busy, 0);
    spur_at_a = real_done_cnt + 5;
    spur_at_b = real_done_cnt + 21;
    s0 = start_cnt; r0 = rd_cnt; d0 = done_cnt;
    build_frame(32'h30, 32'h9);
    push_buf();
    pulse_halt();
    wait_frame("t6", s0, r0, d0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
